// File: rtl/regfile_mp_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_if
// Bus bundle for the multi-port register file.
//   master : datapath / control side (drives addresses, write data, issues)
//   slave  : register file side (returns read data, busy bits, collision)
// Signals:
//   RdAddr/RdData/RdBusy   packed read ports, port k at [k*AW +: AW] / [k*DW +: DW]
//   WrEn0/WrAddr0/WrData0  write port 0
//   WrEn1/WrAddr1/WrData1  write port 1 (wins on a same-address collision)
//   IssueValid/IssueAddr   marks a destination register as pending
//   BusyVec                registered scoreboard, one bit per register
//   WrCollision            registered pulse, both ports hit one address last cycle
// ----------------------------------------------------------------------------
interface regfile_mp_if #(
   parameter int DW     = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2
);
   localparam int AW = $clog2(DEPTH);

   logic [NUM_RD*AW-1:0] RdAddr;
   logic [NUM_RD*DW-1:0] RdData;
   logic [NUM_RD-1:0]    RdBusy;
   logic                 WrEn0;
   logic [AW-1:0]        WrAddr0;
   logic [DW-1:0]        WrData0;
   logic                 WrEn1;
   logic [AW-1:0]        WrAddr1;
   logic [DW-1:0]        WrData1;
   logic                 IssueValid;
   logic [AW-1:0]        IssueAddr;
   logic [DEPTH-1:0]     BusyVec;
   logic                 WrCollision;

   modport master (
      output RdAddr, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1,
             IssueValid, IssueAddr,
      input  RdData, RdBusy, BusyVec, WrCollision
   );

   modport slave (
      input  RdAddr, WrEn0, WrAddr0, WrData0, WrEn1, WrAddr1, WrData1,
             IssueValid, IssueAddr,
      output RdData, RdBusy, BusyVec, WrCollision
   );
endinterface

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file with NUM_RD combinational read ports, two write
// ports, an optional hardwired-zero register 0, a per-register busy
// scoreboard and a registered dual-write collision flag.
// Ports:
//   Clock  rising-edge clock
//   reset  asynchronous, active-low reset (clears registers, scoreboard, flag)
//   bus    regfile_mp_if.slave (read ports, write ports, issue, status)
// Optional feature:
//   REGFILE_MP_BYPASS_EN  when defined, reads forward same-cycle write data
//                         (port 1 over port 0) and report not-busy for a
//                         register being completed this cycle.
// ----------------------------------------------------------------------------
module regfile_mp #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input logic         Clock,
   input logic         reset,
   regfile_mp_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0]    regs_q [DEPTH];
   logic [DW-1:0]    regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic             collision_q, collision_d;

   // ---------------------------------------------------------------- writes
   always_comb begin
      regs_d = regs_q;
      if (bus.WrEn0) regs_d[bus.WrAddr0] = bus.WrData0;
      // Applied after port 0 so port 1 wins a same-address collision.
      if (bus.WrEn1) regs_d[bus.WrAddr1] = bus.WrData1;
      if (ZERO_REG != 0) regs_d[0] = '0;
   end

   // ------------------------------------------------------------ scoreboard
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < DEPTH; i++) begin
         // A new producer takes priority over one completing in the same cycle.
         if (bus.IssueValid && bus.IssueAddr == AW'(i)) begin
            busy_d[i] = 1'b1;
         end else if ((bus.WrEn0 && bus.WrAddr0 == AW'(i)) ||
                      (bus.WrEn1 && bus.WrAddr1 == AW'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
      if (ZERO_REG != 0) busy_d[0] = 1'b0;
   end

   // Collision is reported even on register 0, whose write itself is dropped.
   always_comb begin
      collision_d = bus.WrEn0 && bus.WrEn1 && (bus.WrAddr0 == bus.WrAddr1);
   end

   // ------------------------------------------------------------- registers
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the whole array is reset because software relies on every
         // register reading zero after reset; this rules out a RAM macro.
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q      <= '0;
         collision_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         busy_q      <= busy_d;
         collision_q <= collision_d;
      end
   end

   assign bus.BusyVec     = busy_q;
   assign bus.WrCollision = collision_q;

   // ------------------------------------------------------------ read ports
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_val;
   logic          rd_busy;

   // NOTE: every variable written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      bus.RdData = '0;
      bus.RdBusy = '0;
      rd_addr    = '0;
      rd_val     = '0;
      rd_busy    = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_addr = bus.RdAddr[k*AW +: AW];
         rd_val  = regs_q[rd_addr];
         rd_busy = busy_q[rd_addr];
`ifdef REGFILE_MP_BYPASS_EN
         if (bus.WrEn1 && bus.WrAddr1 == rd_addr) begin
            rd_val = bus.WrData1;
         end else if (bus.WrEn0 && bus.WrAddr0 == rd_addr) begin
            rd_val = bus.WrData0;
         end
         // The forwarded write completes the producer unless a new one is
         // issued to the same register in this cycle.
         if (((bus.WrEn1 && bus.WrAddr1 == rd_addr) ||
              (bus.WrEn0 && bus.WrAddr0 == rd_addr)) &&
             !(bus.IssueValid && bus.IssueAddr == rd_addr)) begin
            rd_busy = 1'b0;
         end
`endif
         if (ZERO_REG != 0 && rd_addr == '0) rd_val = '0;
         bus.RdData[k*DW +: DW] = rd_val;
         bus.RdBusy[k]          = rd_busy;
      end
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the single-cycle core's 32x32 2R1W file.
- Intended for the dual-issue / multi-cycle datapath: configurable width, depth and read-port count, plus two write ports.
- Register 0 is optionally hardwired to zero.
- Per-register busy scoreboard lets the control unit stall on results still in flight; a registered collision flag reports dual writes to the same register.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, >= 4; AW = log2(DEPTH) is a derived localparam.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- Clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- RdAddr  in  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- RdData  out  NUM_RD*DW  packed read data; port k occupies [k*DW +: DW].
- RdBusy  out  NUM_RD  busy bit of the register addressed by each read port.
- WrEn0  in  1  write enable, port 0.
- WrAddr0  in  AW  write address, port 0.
- WrData0  in  DW  write data, port 0.
- WrEn1  in  1  write enable, port 1.
- WrAddr1  in  AW  write address, port 1.
- WrData1  in  DW  write data, port 1.
- IssueValid  in  1  marks register IssueAddr as pending (producer issued).
- IssueAddr  in  AW  destination register of the issued instruction.
- BusyVec  out  DEPTH  registered scoreboard, bit i = register i pending.
- WrCollision  out  1  registered one-cycle pulse: both ports wrote the same address last cycle.

Behaviour:
- Reset (reset low, asynchronous):
  - all registers become 0;
  - BusyVec becomes 0;
  - WrCollision becomes 0.
  - Reset takes effect mid-operation regardless of pending writes or issues.
- Read ports:
  - Combinational, zero latency.
  - RdData[k] = register[RdAddr[k]], before any same-cycle write (no bypass unless the optional feature is enabled).
  - RdBusy[k] = BusyVec[RdAddr[k]].
- Writes:
  - Take effect on the rising edge of Clock when WrEn is high.
  - Both ports write in the same cycle when addresses differ.
  - Same address with both enabled: port 1 wins, port 0 data is discarded, and WrCollision = 1 on the following cycle only. Otherwise WrCollision = 0.
- ZERO_REG = 1:
  - Writes to address 0 are dropped; read of address 0 returns 0.
  - IssueValid to address 0 does not set busy.
  - A collision on address 0 still raises WrCollision.
- Scoreboard, per register i, at each edge:
  - set when IssueValid && IssueAddr == i;
  - else cleared when (WrEn0 && WrAddr0 == i) || (WrEn1 && WrAddr1 == i);
  - else held.
  - Issue and write to the same register in one cycle leaves busy set (new producer overrides the completing one).
  - Issue to an already-busy register keeps it busy; no count is kept.
  - Write to a non-busy register is legal; the write happens and busy stays 0.
- Address range: every AW-bit address is valid, so there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data combinationally when its address matches an enabled write port: port 1 data over port 0 data, else the array value.
  - RdBusy[k] reads 0 when forwarding from a write that clears busy and no same-cycle issue targets that address.
  - ZERO_REG still forces address 0 to read 0.
- Undefined: reads return the array value only; the new value is visible the cycle after the write.

Test Plan:
- Reset while registers hold nonzero values and BusyVec = 0xFFFFFFFE -> all reads 0, BusyVec 0, WrCollision 0, immediately and asynchronously.
- WrEn0 addr 5 data 0xDEADBEEF, WrEn1 addr 9 data 0x12345678 in one cycle -> next cycle RdAddr 5 and 9 return those values; WrCollision 0.
- Both ports write addr 7 (0x1111 on port 0, 0x2222 on port 1) -> reg 7 = 0x2222, WrCollision = 1 for exactly one cycle.
- ZERO_REG = 1: write 0xFFFFFFFF to addr 0 and issue to addr 0 -> read of addr 0 returns 0, BusyVec[0] stays 0.
- Issue addr 3 -> BusyVec[3] = 1, RdBusy = 1 on a port reading addr 3. Next cycle, issue addr 3 plus WrEn0 to addr 3 -> stays 1. Next cycle, write only -> BusyVec[3] clears.
- Bypass: with REGFILE_MP_BYPASS_EN, write 0xCAFEF00D to addr 4 while RdAddr = 4 -> RdData = 0xCAFEF00D in the same cycle. Without the macro -> old value that cycle, new value the next.
